// File: rtl/ahb_adc_pkg.sv
// Shared definitions for the AHB-Lite ADC sample FIFO: bus encodings,
// register offsets (as HADDR[3:2] word selects) and STATUS/CTRL bit positions.
package ahb_adc_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Word index of each register: byte offsets 0x0, 0x4, 0x8, 0xC
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_EMPTY     = 16;
    localparam int STAT_FULL      = 17;
    localparam int STAT_OVF       = 18;
    localparam int STAT_IRQ       = 19;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_CLEAR     = 2;
    localparam int CTRL_DEC_LSB   = 8;
    localparam int CTRL_THR_LSB   = 16;

    function automatic logic is_active(input logic [1:0] trans);
        return (htrans_e'(trans) == HTRANS_NONSEQ) || (htrans_e'(trans) == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock flop-array FIFO; clear wins over push/pop, and a push while full
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ahblite_adc_fifo.sv
// AHB-Lite slave buffering decimated ADC samples: zero-wait-state register
// interface (DATA/STATUS/CTRL), decimator, overflow tracking and level irq.
module ahblite_adc_fifo
    import ahb_adc_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  dp_valid;
    logic                  dp_write;
    reg_sel_e              dp_addr;
    logic                  en;
    logic                  irq_en;
    logic [7:0]            dec;
    logic [7:0]            thr;
    logic [7:0]            dec_cnt;
    logic                  overflow;
    logic                  irq_q;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  rd_active;
    logic                  wr_ctrl;
    logic                  wr_status;
    logic                  clear;
    logic                  pop;
    logic                  push;
    logic                  ovf_set;
    logic                  irq_next;
    logic [8:0]            count_ext;
    logic [31:0]           status_word;
    logic [31:0]           ctrl_word;
    logic [31:0]           rdata;
    logic                  unused;

    assign unused    = ^{HADDR[31:4], HADDR[1:0], HSIZE, HPROT, HWDATA[31:24], HWDATA[7:3]};
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign HRDATA    = rdata;
    assign irq       = irq_q;

    assign accept    = HSEL & HREADY & is_active(HTRANS);
    assign rd_active = dp_valid & ~dp_write;
    assign wr_ctrl   = dp_valid & dp_write & (dp_addr == REG_CTRL);
    assign wr_status = dp_valid & dp_write & (dp_addr == REG_STATUS);
    assign clear     = wr_ctrl & HWDATA[CTRL_CLEAR];
    assign pop       = rd_active & (dp_addr == REG_DATA) & ~fifo_empty;
    assign push      = en & data_valid & (dec_cnt >= dec);
    assign ovf_set   = push & fifo_full & ~pop;
    assign irq_next  = irq_en & (overflow | ((thr != 8'd0) && (count_ext >= {1'b0, thr})));

    // Address phase capture; a reset drops any pending data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= REG_DATA;
        end else begin
            dp_valid <= accept;
            if (accept) begin
                dp_write <= HWRITE;
                dp_addr  <= reg_sel_e'(HADDR[3:2]);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en     <= 1'b0;
            irq_en <= 1'b0;
            dec    <= '0;
            thr    <= '0;
        end else if (wr_ctrl) begin
            en     <= HWDATA[CTRL_EN];
            irq_en <= HWDATA[CTRL_IRQ_EN];
            dec    <= HWDATA[CTRL_DEC_LSB +: 8];
            thr    <= HWDATA[CTRL_THR_LSB +: 8];
        end
    end

    // Compare with >= so a DEC lowered mid-count still fires on the next pulse
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dec_cnt <= '0;
        end else if (clear || !en || push) begin
            dec_cnt <= '0;
        end else if (data_valid) begin
            dec_cnt <= dec_cnt + 8'd1;
        end
    end

    // A dropped sample in the same cycle as a W1C keeps overflow set
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (wr_status && HWDATA[STAT_OVF]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) irq_q <= 1'b0;
        else          irq_q <= irq_next;
    end

    always_comb begin
        count_ext             = '0;
        count_ext[CW-1:0]     = fifo_count;
        status_word           = '0;
        status_word[STAT_COUNT_LSB +: 9] = count_ext;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_OVF]   = overflow;
        status_word[STAT_IRQ]   = irq_q;
        ctrl_word               = '0;
        ctrl_word[CTRL_EN]      = en;
        ctrl_word[CTRL_IRQ_EN]  = irq_en;
        ctrl_word[CTRL_DEC_LSB +: 8] = dec;
        ctrl_word[CTRL_THR_LSB +: 8] = thr;
        rdata                   = '0;
        if (rd_active) begin
            case (dp_addr)
                REG_DATA:   if (!fifo_empty) rdata[DATA_WIDTH-1:0] = fifo_dout;
                REG_STATUS: rdata = status_word;
                REG_CTRL:   rdata = ctrl_word;
                default:    rdata = '0;
            endcase
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: doc/ahblite_adc_fifo.md
AHBLITE_ADC_FIFO -- requirements
Module: ahblite_adc_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, the sample width; legal range 1..32.
REQ-002 SHALL have parameter DEPTH, default 16, the FIFO depth in samples; power of two, 2..256.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port HRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have AHB-Lite slave inputs HSEL 1, HADDR 32, HTRANS 2, HSIZE 3, HPROT 4, HWRITE 1, HWDATA 32 and HREADY 1.
REQ-006 SHALL have AHB-Lite slave outputs HREADYOUT 1, HRDATA 32 and HRESP 1.
REQ-007 SHALL have port data_in, input, DATA_WIDTH bits: the ADC sample.
REQ-008 SHALL have port data_valid, input, 1 bit: a one-cycle strobe marking data_in valid.
REQ-009 SHALL have port irq, output, 1 bit: a level interrupt.

Function
REQ-010 SHALL accept a transfer only when HSEL=1, HREADY=1 and HTRANS[1]=1, registering HADDR[3:2] and HWRITE in the address phase.
REQ-011 SHALL keep HREADYOUT=1 (zero wait states) and HRESP=0 (OKAY) at all times.
REQ-012 SHALL use register map 0x0 DATA (RO), 0x4 STATUS, 0x8 CTRL (RW); offset 0xC reads 0 and ignores writes.
REQ-013 SHALL take write data from HWDATA in the data phase and update the register at the end of that cycle.
REQ-014 SHALL drive HRDATA combinationally in the data phase from the registered address, and 0 when no read is active.
REQ-015 SHALL return the FIFO head sample zero-extended on a DATA read, then pop it at the end of the data phase.
REQ-016 SHALL return 0 on a DATA read when the FIFO is empty, with no pop and no pointer change.
REQ-017 SHALL format STATUS as [8:0] count, [16] empty, [17] full, [18] overflow (sticky), [19] irq.
REQ-018 SHALL clear overflow on a STATUS write with HWDATA[18]=1 (write-1-to-clear); all other STATUS bits ignore writes.
REQ-019 SHALL format CTRL as [0] EN, [1] IRQ_EN, [2] CLEAR, [15:8] DEC, [23:16] THR.
REQ-020 SHALL make CLEAR self-clearing and read as 0.
REQ-021 SHALL, on a write with CLEAR=1, empty the FIFO, zero the decimation counter and clear overflow in the same edge.
REQ-022 SHALL apply decimation only while EN=1: count data_valid pulses and push data_in on every (DEC+1)-th pulse, so DEC=0 pushes every pulse.
REQ-023 SHALL zero the decimation counter on each push, on CLEAR and while EN=0.
REQ-024 SHALL, on a push while full, drop the sample, set overflow and leave the FIFO unchanged.
REQ-025 SHALL, on a pop while full with a simultaneous push, perform both and keep count unchanged.
REQ-026 SHALL, on a simultaneous push and pop when not full and not empty, perform both and keep count unchanged.
REQ-027 SHALL, on a simultaneous push and pop when empty, perform the push only, since the read returns 0 per REQ-016.
REQ-028 SHALL give CLEAR priority over a same-cycle push and pop.
REQ-029 SHALL make a pushed sample visible in count and DATA on the cycle after the data_valid edge, a latency of one cycle.
REQ-030 SHALL let the write and read pointers wrap modulo DEPTH, with count ranging 0..DEPTH.
REQ-031 SHALL compute irq as IRQ_EN & (overflow | (THR!=0 & count>=THR)), registered so it updates one cycle after its cause.

Reset
REQ-032 SHALL, on HRESETn=0, immediately set pointers, count, decimation counter, overflow, CTRL and irq to 0, with HRDATA=0, HREADYOUT=1 and HRESP=0.
REQ-033 SHALL, on reset mid-transfer, abandon the pending data phase with no pop or write after release.

Structure
REQ-034 SHALL place register offsets, STATUS and CTRL bit positions and HTRANS encodings in shared package ahb_adc_pkg.
REQ-035 SHALL implement storage as one sub-module sync_fifo (parameters DATA_WIDTH, DEPTH; push, pop, dout, count, full, empty) using a flop array, not a macro.
REQ-036 SHALL contain the bus decode, registers, decimator and irq in the top level.

Verification
REQ-037 SHALL verify decimation: EN=1, DEC=2, 9 data_valid pulses carrying 1..9 -> count=3, and DATA reads return 3, 6, 9 then 0.
REQ-038 SHALL verify overflow: DEPTH=16, DEC=0, 17 pushes -> full=1, overflow=1, count=16, first read=sample 1, then STATUS write 0x40000 -> overflow=0.
REQ-039 SHALL verify concurrent access: FIFO full, a push coincident with a DATA read data phase -> count stays 16, overflow stays 0, and the new sample is last out.
REQ-040 SHALL verify irq threshold: IRQ_EN=1, THR=4, four pushes -> irq rises one cycle after the 4th push, falls one cycle after the next pop.
REQ-041 SHALL verify CLEAR: 5 samples stored and CLEAR written with a same-cycle push -> count=0, empty=1, CTRL reads back with bit 2 = 0.
REQ-042 SHALL verify reset: HRESETn asserted during a DATA read data phase -> all outputs at reset values at once, and no pop after release.
